// File: rtl/speck_pkg.sv
// speck_pkg: shared widths, rotation amounts, controller states
// and 64-bit rotate helpers for the SPECK128/128 datapath.
package speck_pkg;

  localparam int WORD_W    = 64;
  localparam int BLOCK_W   = 128;
  localparam int ROT_ALPHA = 8;
  localparam int ROT_BETA  = 3;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } ctrl_st_e;

  function automatic logic [WORD_W-1:0] ror64(
    input logic [WORD_W-1:0] v,
    input int                n
  );
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol64(
    input logic [WORD_W-1:0] v,
    input int                n
  );
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/speck_round_ctrl_if.sv
// speck_round_ctrl_if: block-in / ciphertext-out valid/ready bundle
// between the cipher wrapper (master) and the round controller (slave).
interface speck_round_ctrl_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [speck_pkg::BLOCK_W-1:0] key;
  logic [speck_pkg::BLOCK_W-1:0] plaintext;
  logic                         out_valid;
  logic                         out_ready;
  logic [speck_pkg::BLOCK_W-1:0] ciphertext;

  modport master (
    output in_valid, key, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, key, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/speck_key_sched.sv
// speck_key_sched: one combinational SPECK key-schedule step,
// (k, l, i) -> (k', l'), all arithmetic mod 2^64.
module speck_key_sched
  import speck_pkg::*;
#(
  parameter int IW = 5
) (
  input  logic [WORD_W-1:0] i_k,
  input  logic [WORD_W-1:0] i_l,
  input  logic [IW-1:0]     i_i,
  output logic [WORD_W-1:0] o_k,
  output logic [WORD_W-1:0] o_l
);

  logic [WORD_W-1:0] w_l;

  assign w_l = (i_k + ror64(i_l, ROT_ALPHA)) ^ WORD_W'(i_i);
  assign o_l = w_l;
  assign o_k = rol64(i_k, ROT_BETA) ^ w_l;

endmodule

// File: rtl/speck_round_ctrl.sv
// speck_round_ctrl: sequences NUM_ROUNDS calls of a shared round unit.
// Optional WAIT watchdog: define SPECK_ROUND_TIMEOUT_EN.
module speck_round_ctrl
  import speck_pkg::*;
#(
  parameter int NUM_ROUNDS     = 32,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  speck_round_ctrl_if.slave  bus,
  output logic               rnd_start,
  output logic [WORD_W-1:0]  rnd_subkey,
  output logic [BLOCK_W-1:0] rnd_plaintext,
  input  logic [BLOCK_W-1:0] rnd_ciphertext,
  input  logic               rnd_finished,
  output logic               busy,
  output logic               err
);

  localparam int IW   = $clog2(NUM_ROUNDS);
  localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES)
                      ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_I = IW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] LAST_S = CW'(SETTLE_CYCLES - 1);
`ifdef SPECK_ROUND_TIMEOUT_EN
  localparam logic [CW-1:0] LAST_T = CW'(TIMEOUT_CYCLES - 1);
`endif

  ctrl_st_e           r_st;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_i;
  logic [WORD_W-1:0]  r_k;
  logic [WORD_W-1:0]  r_l;
  logic [BLOCK_W-1:0] r_blk;
  logic [BLOCK_W-1:0] r_ct;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_start;
  logic               r_busy;
  logic               r_err;
  logic [WORD_W-1:0]  w_k_nxt;
  logic [WORD_W-1:0]  w_l_nxt;

  speck_key_sched #(
    .IW (IW)
  ) u_ks (
    .i_k (r_k),
    .i_l (r_l),
    .i_i (r_i),
    .o_k (w_k_nxt),
    .o_l (w_l_nxt)
  );

  // Controller FSM; r_cnt serves SETTLE and the WAIT watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= ST_SETTLE;
      r_cnt       <= '0;
      r_i         <= '0;
      r_k         <= '0;
      r_l         <= '0;
      r_blk       <= '0;
      r_ct        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_st)
        ST_SETTLE: begin
          if (r_cnt == LAST_S) begin
            r_st       <= ST_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_blk      <= bus.plaintext;
            r_k        <= bus.key[WORD_W-1:0];
            r_l        <= bus.key[BLOCK_W-1:WORD_W];
            r_i        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_start    <= 1'b1;
            r_st       <= ST_START;
          end
        end
        ST_START: begin
          r_cnt <= '0;
          r_st  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rnd_finished) begin
            r_blk <= rnd_ciphertext;
            r_st  <= ST_NEXT;
          end
`ifdef SPECK_ROUND_TIMEOUT_EN
          else if (r_cnt == LAST_T) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_st   <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_NEXT: begin
          r_k <= w_k_nxt;
          r_l <= w_l_nxt;
          if (r_i == LAST_I) begin
            r_ct        <= r_blk;
            r_out_valid <= 1'b1;
            r_st        <= ST_DONE;
          end else begin
            r_i     <= r_i + 1'b1;
            r_start <= 1'b1;
            r_st    <= ST_START;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_st        <= ST_IDLE;
          end
        end
        default: r_st <= ST_SETTLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.ciphertext = r_ct;
  assign rnd_start      = r_start;
  assign rnd_subkey     = r_k;
  assign rnd_plaintext  = r_blk;
  assign busy           = r_busy;
`ifdef SPECK_ROUND_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
  logic w_unused;
  assign w_unused = r_err;
`endif

endmodule

// File: tb/tb_speck_round_ctrl.sv
// tb_speck_round_ctrl: directed vectors against a SPECK round model
// (L=7); golden cipher and key schedule computed in the bench.
module tb_speck_round_ctrl;

  localparam int L = 7;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rnd_start;
  logic [63:0]  rnd_subkey;
  logic [127:0] rnd_plaintext;
  logic [127:0] rnd_ciphertext = '0;
  logic         rnd_finished = 1'b0;
  logic         busy;
  logic         err;

  speck_round_ctrl_if bus ();

  speck_round_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .rnd_start      (rnd_start),
    .rnd_subkey     (rnd_subkey),
    .rnd_plaintext  (rnd_plaintext),
    .rnd_ciphertext (rnd_ciphertext),
    .rnd_finished   (rnd_finished),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol_a  = 0;
  int viol_b  = 0;
  int acc_cnt = 0;
  int hs_cnt  = 0;
  int m_cnt   = 0;
  bit hang    = 1'b0;
  bit inj     = 1'b0;
  bit prev_st = 1'b0;
  logic [63:0]  m_sk;
  logic [127:0] m_pt;
  logic [127:0] m_res;
  logic [63:0]  sk_q[$];
  vec_t         vt[4];

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] round_f(
    input logic [127:0] p, input logic [63:0] k);
    logic [63:0] x, y;
    x = p[127:64];
    y = p[63:0];
    x = (ror(x, 8) + y) ^ k;
    y = rol(y, 3) ^ x;
    return {x, y};
  endfunction

  function automatic logic [63:0] gold_sk(input logic [127:0] key, input int n);
    logic [63:0] k, l;
    k = key[63:0];
    l = key[127:64];
    for (int j = 0; j < n; j++) begin
      l = (k + ror(l, 8)) ^ 64'(j);
      k = rol(k, 3) ^ l;
    end
    return k;
  endfunction

  function automatic logic [127:0] speck_enc(
    input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int j = 0; j < 32; j++) s = round_f(s, gold_sk(key, j));
    return s;
  endfunction

  // Behavioural round: result L edges after the start sample.
  always @(posedge clk) begin
    rnd_finished <= 1'b0;
    if (inj) rnd_finished <= 1'b1;
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !hang) begin
        rnd_finished   <= 1'b1;
        rnd_ciphertext <= m_res;
        if (busy && (rnd_subkey !== m_sk || rnd_plaintext !== m_pt))
          viol_a++;
      end
    end
    if (rnd_start) begin
      m_cnt <= L;
      m_sk  <= rnd_subkey;
      m_pt  <= rnd_plaintext;
      m_res <= round_f(rnd_plaintext, rnd_subkey);
      sk_q.push_back(rnd_subkey);
    end
  end

  // Protocol monitor and handshake counters.
  always @(posedge clk) begin
    if (rnd_start) begin
      if (prev_st) viol_b++;
      if (!busy || bus.in_ready || bus.out_valid) viol_b++;
      if (m_cnt > 0) viol_b++;
    end
    prev_st = rnd_start;
    if (bus.in_valid && bus.in_ready) acc_cnt++;
    if (bus.out_valid && bus.out_ready) hs_cnt++;
  end

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] p);
    int c;
    c = 0;
    while (!bus.in_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("in_ready_wait", 128'(bus.in_ready), 128'd1);
    bus.key       = k;
    bus.plaintext = p;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int c;
    c = 0;
    while (!bus.out_valid && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("out_valid_wait", 128'(bus.out_valid), 128'd1);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", 128'(bus.out_valid), 128'd0);
    check("idle_ready", 128'(bus.in_ready), 128'd1);
  endtask

  task automatic settle_chk(input bit do_inj);
    bit bad;
    bad = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      inj = do_inj && (k == 2);
      if (bus.in_ready || bus.out_valid || busy) bad = 1'b1;
    end
    inj = 1'b0;
    check("settle_low", 128'(bad), 128'd0);
    @(negedge clk);
    check("settle_ready", 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] hold;
    bit           bad;
    int           c, a0, h0;

    vt[0].key = 128'h0f0e0d0c0b0a0908_0706050403020100;
    vt[0].pt  = 128'h6c61766975716520_7469206564616d20;
    vt[0].ct  = 128'ha65d985179783265_7860fedf5c570d18;
    vt[1].key = 128'h0011223344556677_8899aabbccddeeff;
    vt[1].pt  = 128'h0123456789abcdef_fedcba9876543210;
    vt[2].key = '0;
    vt[2].pt  = '0;
    vt[3].key = '1;
    vt[3].pt  = 128'h8000000000000000_0000000000000001;
    for (int v = 1; v < 4; v++) vt[v].ct = speck_enc(vt[v].key, vt[v].pt);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.key       = '0;
    bus.plaintext = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_start_busy_err", {125'd0, rnd_start, busy, err}, 128'd0);
    check("rst_ct", bus.ciphertext, 128'd0);
    check("rst_rnd_pt", rnd_plaintext, 128'd0);
    check("rst_subkey", 128'(rnd_subkey), 128'd0);
    rst_n = 1'b1;
    settle_chk(1'b0);

    for (int v = 0; v < 4; v++) begin
      sk_q.delete();
      send(vt[v].key, vt[v].pt);
      check("busy_run", {126'd0, busy, bus.in_ready}, 128'd2);
      wait_out();
      check("ct", bus.ciphertext, vt[v].ct);
      check("sk_count", 128'(sk_q.size()), 128'd32);
      for (int j = 0; j < 32; j++)
        check("subkey", 128'(sk_q[j]), 128'(gold_sk(vt[v].key, j)));
      if (v == 0)
        check("subkey0", 128'(sk_q[0]), 128'h0706050403020100);
      ack();
    end

    send(vt[0].key, vt[0].pt);
    wait_out();
    hold = bus.ciphertext;
    bad  = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.ciphertext !== hold || bus.in_ready || !bus.out_valid)
        bad = 1'b1;
    end
    check("bp_stable", 128'(bad), 128'd0);
    check("bp_ct", bus.ciphertext, vt[0].ct);
    ack();

    sk_q.delete();
    send(vt[1].key, vt[1].pt);
    c = 0;
    while (sk_q.size() < 10 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("mid_round10", 128'(sk_q.size()), 128'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags",
          {124'd0, bus.in_ready, bus.out_valid, rnd_start, busy}, 128'd0);
    check("mid_rst_ct", bus.ciphertext, 128'd0);
    check("mid_rst_pt", rnd_plaintext, 128'd0);
    check("mid_rst_sk", 128'(rnd_subkey), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    settle_chk(1'b1);
    sk_q.delete();
    send(vt[0].key, vt[0].pt);
    wait_out();
    check("post_rst_ct", bus.ciphertext, vt[0].ct);
    ack();

`ifdef SPECK_ROUND_TIMEOUT_EN
    hang = 1'b1;
    send(vt[0].key, vt[0].pt);
    bad = 1'b0;
    c   = 0;
    while (!err && c < 60) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1'b1;
      c++;
    end
    check("to_err", 128'(err), 128'd1);
    c = 0;
    while (!bus.in_ready && c < 30) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1'b1;
      c++;
    end
    check("to_no_out", 128'(bad), 128'd0);
    check("to_idle", 128'(bus.in_ready), 128'd1);
    hang = 1'b0;
`endif

    a0 = acc_cnt;
    h0 = hs_cnt;
    bus.key       = vt[1].key;
    bus.plaintext = vt[1].pt;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    c = 0;
    while (acc_cnt - a0 < 3 && c < 1500) begin
      @(negedge clk);
      c++;
    end
    bus.in_valid = 1'b0;
    c = 0;
    while (hs_cnt - h0 < 3 && c < 600) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_accepts", 128'(acc_cnt - a0), 128'd3);
    check("b2b_handshakes", 128'(hs_cnt - h0), 128'd3);
    check("b2b_ct", bus.ciphertext, vt[1].ct);

    check("rnd_protocol", 128'(viol_a + viol_b), 128'd0);
`ifdef SPECK_ROUND_TIMEOUT_EN
    check("err_final", 128'(err), 128'd1);
`else
    check("err_final", 128'(err), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
